// File: rtl/pipe_dec_exe_cond_pkg.sv
// Shared ARM pipeline types: condition codes, NZCV flag positions and the Execute control bundle.
// Imported by the Decode->Execute register and the reusable condition checker.
package arm_pipe_pkg;

  typedef enum logic [3:0] {
    EQ = 4'h0, NE = 4'h1, CS = 4'h2, CC = 4'h3,
    MI = 4'h4, PL = 4'h5, VS = 4'h6, VC = 4'h7,
    HI = 4'h8, LS = 4'h9, GE = 4'hA, LT = 4'hB,
    GT = 4'hC, LE = 4'hD, AL = 4'hE, NV = 4'hF
  } cond_e;

  localparam int N_IDX  = 3;
  localparam int Z_IDX  = 2;
  localparam int C_IDX  = 1;
  localparam int V_IDX  = 0;
  localparam int FLAG_W = 4;

  // A flushed slot must never be squashed by a stale condition, so bubbles carry AL.
  localparam cond_e COND_AL = AL;

  typedef struct packed {
    logic       pcsrc;
    logic       reg_write;
    logic       mem_to_reg;
    logic       mem_write;
    logic       branch;
    logic       alu_src;
    logic [1:0] alu_control;
    logic [1:0] flag_write;
  } exe_ctrl_t;

endpackage

// File: rtl/pipe_dec_exe_cond_cond_check.sv
// Pure combinational ARM condition evaluation: condition field + NZCV -> pass.
// Shared by Execute and any later stage that needs to re-check a condition.
module cond_check
  import arm_pipe_pkg::*;
(
  input  logic [3:0]        cond_i,
  input  logic [FLAG_W-1:0] flags_i,
  output logic              pass_o
);

  logic n, z, c, v;

  assign n = flags_i[N_IDX];
  assign z = flags_i[Z_IDX];
  assign c = flags_i[C_IDX];
  assign v = flags_i[V_IDX];

  always_comb begin
    pass_o = 1'b0;
    case (cond_e'(cond_i))
      EQ: pass_o = z;
      NE: pass_o = !z;
      CS: pass_o = c;
      CC: pass_o = !c;
      MI: pass_o = n;
      PL: pass_o = !n;
      VS: pass_o = v;
      VC: pass_o = !v;
      HI: pass_o = c & !z;
      LS: pass_o = !c | z;
      GE: pass_o = (n == v);
      LT: pass_o = (n != v);
      GT: pass_o = !z & (n == v);
      LE: pass_o = z | (n != v);
      AL: pass_o = 1'b1;
      NV: pass_o = 1'b0;
      default: pass_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/pipe_dec_exe_cond.sv
// Decode->Execute pipeline register with the architectural NZCV register and condition gating.
// One-cycle latency; stall holds everything, flush loads an AL bubble (flush beats stall).
module pipe_dec_exe_cond
  import arm_pipe_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int RA_W   = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              stall_e,
  input  logic              flush_e,
  input  logic              PCSrcD,
  input  logic              RegWriteD,
  input  logic              MemToRegD,
  input  logic              MemWriteD,
  input  logic              BranchD,
  input  logic              ALUSrcD,
  input  logic [1:0]        ALUControlD,
  input  logic [1:0]        FlagWriteD,
  input  logic [3:0]        CondD,
  input  logic [DATA_W-1:0] RD1D,
  input  logic [DATA_W-1:0] RD2D,
  input  logic [DATA_W-1:0] ExtImmD,
  input  logic [RA_W-1:0]   WA3D,
  input  logic [RA_W-1:0]   RA1D,
  input  logic [RA_W-1:0]   RA2D,
  input  logic [3:0]        ALUFlagsE,
  output logic [DATA_W-1:0] RD1E,
  output logic [DATA_W-1:0] RD2E,
  output logic [DATA_W-1:0] ExtImmE,
  output logic [RA_W-1:0]   WA3E,
  output logic [RA_W-1:0]   RA1E,
  output logic [RA_W-1:0]   RA2E,
  output logic [1:0]        ALUControlE,
  output logic              ALUSrcE,
  output logic              MemToRegE,
  output logic [3:0]        CondE,
  output logic              CondExE,
  output logic              PCSrcE,
  output logic              RegWriteE,
  output logic              MemWriteE,
  output logic              BranchTakenE,
  output logic [3:0]        FlagsQ
);

  exe_ctrl_t         ctrl_q, ctrl_d, ctrl_in;
  logic [3:0]        cond_q, cond_d;
  logic [DATA_W-1:0] rd1_q, rd1_d, rd2_q, rd2_d, imm_q, imm_d;
  logic [RA_W-1:0]   wa3_q, wa3_d, ra1_q, ra1_d, ra2_q, ra2_d;
  logic [3:0]        flags_q, flags_d;
  logic              cond_pass;

  assign ctrl_in = '{pcsrc: PCSrcD, reg_write: RegWriteD, mem_to_reg: MemToRegD,
                     mem_write: MemWriteD, branch: BranchD, alu_src: ALUSrcD,
                     alu_control: ALUControlD, flag_write: FlagWriteD};

  cond_check u_cond_check (
    .cond_i  (cond_q),
    .flags_i (flags_q),
    .pass_o  (cond_pass)
  );

  always_comb begin
    ctrl_d = ctrl_q;
    cond_d = cond_q;
    rd1_d  = rd1_q;
    rd2_d  = rd2_q;
    imm_d  = imm_q;
    wa3_d  = wa3_q;
    ra1_d  = ra1_q;
    ra2_d  = ra2_q;
    if (flush_e) begin
      ctrl_d = '0;
      cond_d = COND_AL;
      rd1_d  = '0;
      rd2_d  = '0;
      imm_d  = '0;
      wa3_d  = '0;
      ra1_d  = '0;
      ra2_d  = '0;
    end else if (!stall_e) begin
      ctrl_d = ctrl_in;
      cond_d = CondD;
      rd1_d  = RD1D;
      rd2_d  = RD2D;
      imm_d  = ExtImmD;
      wa3_d  = WA3D;
      ra1_d  = RA1D;
      ra2_d  = RA2D;
    end
  end

  // The instruction already in E still retires its flag write when the incoming slot is flushed.
  always_comb begin
    flags_d = flags_q;
    if (!stall_e && cond_pass) begin
      if (ctrl_q.flag_write[1]) begin
        flags_d[N_IDX] = ALUFlagsE[N_IDX];
        flags_d[Z_IDX] = ALUFlagsE[Z_IDX];
      end
      if (ctrl_q.flag_write[0]) begin
        flags_d[C_IDX] = ALUFlagsE[C_IDX];
        flags_d[V_IDX] = ALUFlagsE[V_IDX];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ctrl_q  <= '0;
      cond_q  <= '0;
      rd1_q   <= '0;
      rd2_q   <= '0;
      imm_q   <= '0;
      wa3_q   <= '0;
      ra1_q   <= '0;
      ra2_q   <= '0;
      flags_q <= '0;
    end else begin
      ctrl_q  <= ctrl_d;
      cond_q  <= cond_d;
      rd1_q   <= rd1_d;
      rd2_q   <= rd2_d;
      imm_q   <= imm_d;
      wa3_q   <= wa3_d;
      ra1_q   <= ra1_d;
      ra2_q   <= ra2_d;
      flags_q <= flags_d;
    end
  end

  assign RD1E         = rd1_q;
  assign RD2E         = rd2_q;
  assign ExtImmE      = imm_q;
  assign WA3E         = wa3_q;
  assign RA1E         = ra1_q;
  assign RA2E         = ra2_q;
  assign ALUControlE  = ctrl_q.alu_control;
  assign ALUSrcE      = ctrl_q.alu_src;
  assign MemToRegE    = ctrl_q.mem_to_reg;
  assign CondE        = cond_q;
  assign CondExE      = cond_pass;
  assign PCSrcE       = ctrl_q.pcsrc & cond_pass;
  assign RegWriteE    = ctrl_q.reg_write & cond_pass;
  assign MemWriteE    = ctrl_q.mem_write & cond_pass;
  assign BranchTakenE = ctrl_q.branch & cond_pass;
  assign FlagsQ       = flags_q;

endmodule

// File: tb/tb_pipe_dec_exe_cond.sv
// Directed bench for pipe_dec_exe_cond: a reference model pushes expected E-stage state into a
// scoreboard queue when each step is driven; entries are popped and compared after the edge.
module tb_pipe_dec_exe_cond;

  typedef struct packed {
    logic        pcsrc, regwrite, memtoreg, memwrite, branch, alusrc;
    logic [1:0]  aluc, fw;
    logic [3:0]  cond;
    logic [31:0] rd1, rd2, imm;
    logic [3:0]  wa3, ra1, ra2;
  } tbreg_t;

  typedef struct packed {
    tbreg_t     r;
    logic [3:0] flags;
    logic       condex, pcsrc_e, regwrite_e, memwrite_e, btaken_e;
  } exp_t;

  logic clk;
  logic rst_n, stall_e, flush_e;
  logic [3:0] alu_flags;
  tbreg_t din;

  logic [31:0] RD1E, RD2E, ExtImmE;
  logic [3:0]  WA3E, RA1E, RA2E, CondE, FlagsQ;
  logic [1:0]  ALUControlE;
  logic        ALUSrcE, MemToRegE, CondExE, PCSrcE, RegWriteE, MemWriteE, BranchTakenE;

  int checks = 0;
  int failures = 0;

  tbreg_t     m_q;
  logic [3:0] m_flags;
  exp_t       sb[$];

  pipe_dec_exe_cond #(.DATA_W(32), .RA_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .stall_e(stall_e), .flush_e(flush_e),
    .PCSrcD(din.pcsrc), .RegWriteD(din.regwrite), .MemToRegD(din.memtoreg),
    .MemWriteD(din.memwrite), .BranchD(din.branch), .ALUSrcD(din.alusrc),
    .ALUControlD(din.aluc), .FlagWriteD(din.fw), .CondD(din.cond),
    .RD1D(din.rd1), .RD2D(din.rd2), .ExtImmD(din.imm),
    .WA3D(din.wa3), .RA1D(din.ra1), .RA2D(din.ra2), .ALUFlagsE(alu_flags),
    .RD1E(RD1E), .RD2E(RD2E), .ExtImmE(ExtImmE), .WA3E(WA3E), .RA1E(RA1E), .RA2E(RA2E),
    .ALUControlE(ALUControlE), .ALUSrcE(ALUSrcE), .MemToRegE(MemToRegE), .CondE(CondE),
    .CondExE(CondExE), .PCSrcE(PCSrcE), .RegWriteE(RegWriteE), .MemWriteE(MemWriteE),
    .BranchTakenE(BranchTakenE), .FlagsQ(FlagsQ)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference condition table, flags ordered {N,Z,C,V}.
  function automatic logic cpass(input logic [3:0] c, input logic [3:0] f);
    logic n, z, cy, v;
    {n, z, cy, v} = f;
    case (c)
      4'h0: return z;
      4'h1: return !z;
      4'h2: return cy;
      4'h3: return !cy;
      4'h4: return n;
      4'h5: return !n;
      4'h6: return v;
      4'h7: return !v;
      4'h8: return cy && !z;
      4'h9: return !cy || z;
      4'hA: return n == v;
      4'hB: return n != v;
      4'hC: return !z && (n == v);
      4'hD: return z || (n != v);
      4'hE: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic compare(input exp_t e);
    check("RD1E", RD1E, e.r.rd1);
    check("RD2E", RD2E, e.r.rd2);
    check("ExtImmE", ExtImmE, e.r.imm);
    check("WA3E", {28'd0, WA3E}, {28'd0, e.r.wa3});
    check("RA1E", {28'd0, RA1E}, {28'd0, e.r.ra1});
    check("RA2E", {28'd0, RA2E}, {28'd0, e.r.ra2});
    check("ALUControlE", {30'd0, ALUControlE}, {30'd0, e.r.aluc});
    check("ALUSrcE", {31'd0, ALUSrcE}, {31'd0, e.r.alusrc});
    check("MemToRegE", {31'd0, MemToRegE}, {31'd0, e.r.memtoreg});
    check("CondE", {28'd0, CondE}, {28'd0, e.r.cond});
    check("FlagsQ", {28'd0, FlagsQ}, {28'd0, e.flags});
    check("CondExE", {31'd0, CondExE}, {31'd0, e.condex});
    check("PCSrcE", {31'd0, PCSrcE}, {31'd0, e.pcsrc_e});
    check("RegWriteE", {31'd0, RegWriteE}, {31'd0, e.regwrite_e});
    check("MemWriteE", {31'd0, MemWriteE}, {31'd0, e.memwrite_e});
    check("BranchTakenE", {31'd0, BranchTakenE}, {31'd0, e.btaken_e});
  endtask

  // Drive one cycle: advance the model, push its expectation, clock, then pop and compare.
  task automatic step(input logic rst, input logic st, input logic fl, input logic [3:0] aluf);
    logic p;
    exp_t e;
    rst_n = rst; stall_e = st; flush_e = fl; alu_flags = aluf;
    p = cpass(m_q.cond, m_flags);
    if (!rst) begin
      m_q = '0;
      m_flags = 4'h0;
    end else begin
      if (!st && p) begin
        if (m_q.fw[1]) m_flags[3:2] = aluf[3:2];
        if (m_q.fw[0]) m_flags[1:0] = aluf[1:0];
      end
      if (fl) begin
        m_q = '0;
        m_q.cond = 4'hE;
      end else if (!st) begin
        m_q = din;
      end
    end
    e.r = m_q;
    e.flags = m_flags;
    e.condex = cpass(m_q.cond, m_flags);
    e.pcsrc_e = m_q.pcsrc & e.condex;
    e.regwrite_e = m_q.regwrite & e.condex;
    e.memwrite_e = m_q.memwrite & e.condex;
    e.btaken_e = m_q.branch & e.condex;
    sb.push_back(e);
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      checks++; failures++;
      $display("FAIL scoreboard_empty observed=0 expected=1");
    end else begin
      compare(sb.pop_front());
    end
  endtask

  function automatic tbreg_t instr(input logic [3:0] c, input logic [1:0] fw, input logic br,
                                   input logic rw, input logic [31:0] tag);
    tbreg_t r;
    r = '0;
    r.cond = c; r.fw = fw; r.branch = br; r.regwrite = rw;
    r.rd1 = tag; r.rd2 = ~tag; r.imm = tag ^ 32'h5A5A_0000;
    r.wa3 = tag[3:0]; r.ra1 = tag[7:4]; r.ra2 = tag[11:8];
    r.aluc = tag[13:12]; r.alusrc = tag[14]; r.memtoreg = tag[15];
    r.memwrite = rw; r.pcsrc = tag[16];
    return r;
  endfunction

  initial begin
    m_q = '0;
    m_flags = 4'h0;
    rst_n = 1'b0; stall_e = 1'b0; flush_e = 1'b0; alu_flags = 4'h0;

    // Reset with every D input at all-ones: everything in E must clear.
    din = '1;
    step(1'b0, 1'b0, 1'b0, 4'hF);

    // EQ with Z=0 is squashed; after an ADDS producing Z=1 the next EQ writes.
    din = instr(4'h0, 2'b00, 1'b0, 1'b1, 32'h0001_1234);
    step(1'b1, 1'b0, 1'b0, 4'h0);
    din = instr(4'hE, 2'b11, 1'b0, 1'b1, 32'h0000_2345);
    step(1'b1, 1'b0, 1'b0, 4'h0);
    din = instr(4'h0, 2'b00, 1'b0, 1'b1, 32'h0001_3456);
    step(1'b1, 1'b0, 1'b0, 4'b0100);
    step(1'b1, 1'b0, 1'b0, 4'h0);

    // Two stalled cycles with changing inputs hold everything, then the newest D loads.
    din = instr(4'hE, 2'b11, 1'b1, 1'b1, 32'h0000_7777);
    step(1'b1, 1'b0, 1'b0, 4'h0);
    din = instr(4'h1, 2'b01, 1'b0, 1'b1, 32'h0000_8888);
    step(1'b1, 1'b1, 1'b0, 4'hF);
    din = instr(4'h2, 2'b10, 1'b1, 1'b0, 32'h0001_9999);
    step(1'b1, 1'b1, 1'b0, 4'hA);
    step(1'b1, 1'b0, 1'b0, 4'h9);

    // Flush wins over stall and leaves an AL bubble.
    din = instr(4'h3, 2'b11, 1'b1, 1'b1, 32'h0001_ABCD);
    din.pcsrc = 1'b1;
    step(1'b1, 1'b1, 1'b1, 4'h5);
    step(1'b1, 1'b0, 1'b0, 4'h0);

    // Every condition against every flag value: set flags, then test a branch under cond c.
    for (int f = 0; f < 16; f++) begin
      for (int c = 0; c < 16; c++) begin
        din = instr(4'hE, 2'b11, 1'b0, 1'b0, 32'h0000_0100 + 32'(c));
        step(1'b1, 1'b0, 1'b0, 4'h0);
        din = instr(4'(c), 2'b00, 1'b1, 1'b1, 32'h0001_0200 + 32'(f));
        step(1'b1, 1'b0, 1'b0, 4'(f));
      end
    end

    // C,V-only write from all-zero flags leaves N,Z alone.
    din = instr(4'hE, 2'b11, 1'b0, 1'b0, 32'h0000_0300);
    step(1'b1, 1'b0, 1'b0, 4'h0);
    din = instr(4'hE, 2'b01, 1'b0, 1'b0, 32'h0000_0301);
    step(1'b1, 1'b0, 1'b0, 4'h0);
    din = instr(4'h0, 2'b00, 1'b0, 1'b1, 32'h0000_0302);
    step(1'b1, 1'b0, 1'b0, 4'hF);
    check("FlagsQ_cv_only", {28'd0, FlagsQ}, 32'h3);

    // Flush still lets the instruction already in E write its flags.
    din = instr(4'hE, 2'b11, 1'b0, 1'b0, 32'h0000_0400);
    step(1'b1, 1'b0, 1'b0, 4'h0);
    step(1'b1, 1'b0, 1'b1, 4'h8);
    check("FlagsQ_flush_write", {28'd0, FlagsQ}, 32'h8);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
